// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one external combinational barrel shifter between two requesters
// (0 = EX-stage ALU, 1 = mult/div unit). One request is outstanding at a time.
// Sequence: IDLE (grant) -> EXEC (shifter evaluates registered operands) -> RESP (hold result).
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   reqN_valid/ready        request handshake; ready is combinational, IDLE only
//   reqN_a/b/op             operand, shift amount, operation code of requester N
//   sh_a/sh_b/sh_op         registered operands driven to the shifter
//   sh_rst                  shifter reset, mirrors reset
//   sh_result               shifter output
//   resp_valid/id/data      response handshake, tagged with the owning requester
//   resp_ready              response consumer ready
//   grant_cnt0/grant_cnt1   saturating per-requester grant counters
//                           (only with SHIFT_ARB_STATS_EN defined)
`timescale 1ns/1ps
module shift_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] sh_a,
  output logic [WIDTH-1:0] sh_b,
  output logic [OPW-1:0]   sh_op,
  output logic             sh_rst,
  input  logic [WIDTH-1:0] sh_result,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  input  logic             resp_ready
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             grant0, grant1;

  // Round-robin: on contention the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    unique case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          id_d         = grant1;
          last_grant_d = grant1;
          a_d          = grant1 ? req1_a  : req0_a;
          b_d          = grant1 ? req1_b  : req0_b;
          op_d         = grant1 ? req1_op : req0_op;
          state_d      = StExec;
        end
      end
      StExec: begin
        resp_data_d  = sh_result;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        // No grant in the handshake cycle: readys are only high in StIdle.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sh_a       = a_q;
  assign sh_b       = b_q;
  assign sh_op      = op_q;
  assign sh_rst     = reset;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (grant0 && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
      if (grant1 && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
`timescale 1ns/1ps
module tb_shift_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_op, req1_op;
  logic [WIDTH-1:0] sh_a, sh_b, sh_result, resp_data;
  logic [OPW-1:0]   sh_op;
  logic             sh_rst, resp_valid, resp_id, resp_ready;
`ifdef SHIFT_ARB_STATS_EN
  logic [15:0]      grant_cnt0, grant_cnt1;
`endif

  int errors = 0;
  int checks = 0;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] mon_e;
  logic [1:0]     rdy;

  always #5 clk = ~clk;

  shift_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .sh_a(sh_a), .sh_b(sh_b), .sh_op(sh_op), .sh_rst(sh_rst), .sh_result(sh_result),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_ready(resp_ready)
`ifdef SHIFT_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Reference shifter: SLL only, amounts >= 32 give zero.
  always_comb sh_result = ((sh_op == '0) && (sh_b < 32)) ? (sh_a << sh_b[4:0]) : '0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected {id,data} on each response handshake.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got id=%0d data=%h, want no response", resp_id, resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_id", {31'd0, resp_id}, {31'd0, mon_e[WIDTH]});
        check("resp_data", resp_data, mon_e[WIDTH-1:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [OPW-1:0] op);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Returns at the negedge where a ready was seen (or after the budget expires).
  task automatic wait_grant(output logic [1:0] r);
    r = 2'b00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        r = {req1_ready, req0_ready};
        break;
      end
    end
    if (r == 2'b00) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no ready, want a grant");
    end
  endtask

  task automatic wait_resp();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no response, want one");
    end
    tick();
  endtask

  // One isolated request; fields are scrambled right after the grant.
  task automatic do_one(input string name, input int id, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [OPW-1:0] op,
                        input logic [WIDTH-1:0] exp);
    logic [1:0] r;
    drive(id, 1'b1, a, b, op);
    wait_grant(r);
    check({name, "_grant"}, {30'd0, r}, (id == 0) ? 32'd1 : 32'd2);
    exp_q.push_back({id[0], exp});
    tick();
    drive(id, 1'b0, 32'hDEAD_BEEF, 32'd3, 6'd0);
    wait_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    resp_ready = 1'b1;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    tick();
    @(negedge clk);
    check("sh_rst_hi", {31'd0, sh_rst}, 32'd1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_id", {31'd0, resp_id}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_sh_a", sh_a, 32'd0);
    check("rst_sh_b", sh_b, 32'd0);
    check("rst_sh_op", {26'd0, sh_op}, 32'd0);
    check("sh_rst_lo", {31'd0, sh_rst}, 32'd0);

    // Single request with latency checks.
    tick();
    drive(0, 1'b1, 32'h1, 32'd4, 6'd0);
    @(negedge clk);
    check("single_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
    exp_q.push_back({1'b0, 32'h0000_0010});
    tick();
    drive(0, 1'b0, 32'hDEAD_BEEF, 32'd3, 6'd0);
    @(negedge clk);
    check("lat_n1_valid", {31'd0, resp_valid}, 32'd0);
    check("op_a", sh_a, 32'h1);
    check("op_b", sh_b, 32'd4);
    tick();
    @(negedge clk);
    check("lat_n2_valid", {31'd0, resp_valid}, 32'd1);
    tick();
    drive(1, 1'b1, 32'h8000_0001, 32'd1, 6'd0);
    @(negedge clk);
    check("lat_n3_valid", {31'd0, resp_valid}, 32'd0);
    check("op_hold_a", sh_a, 32'h1);
    check("idle_n3_ready", {30'd0, req1_ready, req0_ready}, 32'd2);
    exp_q.push_back({1'b1, 32'h0000_0002});
    tick();
    drive(1, 1'b0, 32'hDEAD_BEEF, 32'd3, 6'd0);
    wait_resp();

    // Contention after reset: 0,1,0,1.
    do_reset();
    drive(0, 1'b1, 32'h8000_0001, 32'd1, 6'd0);
    drive(1, 1'b1, 32'h8000_0001, 32'd1, 6'd0);
    for (int k = 0; k < 4; k++) begin
      wait_grant(rdy);
      check("rr_grant", {30'd0, rdy}, (k % 2 == 0) ? 32'd1 : 32'd2);
      exp_q.push_back({(k % 2 == 1), 32'h0000_0002});
      wait_resp();
    end
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);

    // Shift amount boundaries and unsupported op.
    do_one("b32", 0, 32'h1, 32'd32, 6'd0, 32'h0);
    do_one("badop", 1, 32'hFFFF_FFFF, 32'd1, 6'b000010, 32'h0);
    do_one("b31", 0, 32'h1, 32'd31, 6'd0, 32'h8000_0000);
    do_one("b8", 1, 32'h1234_5678, 32'd8, 6'd0, 32'h3456_7800);

    // Backpressure: response held, no grants while busy.
    resp_ready = 1'b0;
    drive(0, 1'b1, 32'h3, 32'd2, 6'd0);
    wait_grant(rdy);
    check("bp_grant", {30'd0, rdy}, 32'd1);
    exp_q.push_back({1'b0, 32'h0000_000C});
    tick();
    drive(0, 1'b0, 32'hDEAD_BEEF, 32'd3, 6'd0);
    drive(1, 1'b1, 32'h1, 32'd1, 6'd0);
    @(negedge clk);
    check("bp_exec_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_id", {31'd0, resp_id}, 32'd0);
      check("bp_data", resp_data, 32'h0000_000C);
      check("bp_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    @(negedge clk);
    check("bp_next_rdy", {30'd0, req1_ready, req0_ready}, 32'd2);
    exp_q.push_back({1'b1, 32'h0000_0002});
    tick();
    drive(1, 1'b0, 32'hDEAD_BEEF, 32'd3, 6'd0);
    wait_resp();

    // Reset during EXEC drops the request and restores round-robin priority.
    resp_ready = 1'b0;
    drive(0, 1'b1, 32'h5, 32'd1, 6'd0);
    wait_grant(rdy);
    check("rx_grant", {30'd0, rdy}, 32'd1);
    tick();
    drive(0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rx_no_valid", {31'd0, resp_valid}, 32'd0);
      tick();
    end
    drive(0, 1'b1, 32'h8000_0001, 32'd1, 6'd0);
    drive(1, 1'b1, 32'h8000_0001, 32'd1, 6'd0);
    wait_grant(rdy);
    check("rx_cont_grant", {30'd0, rdy}, 32'd1);
    exp_q.push_back({1'b0, 32'h0000_0002});
    tick();
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    wait_resp();

    // Reset during RESP.
    resp_ready = 1'b0;
    drive(0, 1'b1, 32'h7, 32'd1, 6'd0);
    wait_grant(rdy);
    check("rr2_grant", {30'd0, rdy}, 32'd1);
    tick();
    drive(0, 1'b0, '0, '0, '0);
    tick();
    @(negedge clk);
    check("rr2_in_resp", {31'd0, resp_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rr2_no_valid", {31'd0, resp_valid}, 32'd0);
      tick();
    end
    drive(0, 1'b1, 32'h8000_0001, 32'd1, 6'd0);
    drive(1, 1'b1, 32'h8000_0001, 32'd1, 6'd0);
    wait_grant(rdy);
    check("rr2_cont_grant", {30'd0, rdy}, 32'd1);
    exp_q.push_back({1'b0, 32'h0000_0002});
    tick();
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    wait_resp();

`ifdef SHIFT_ARB_STATS_EN
    do_reset();
    @(negedge clk);
    check("cnt0_rst", {16'd0, grant_cnt0}, 32'd0);
    tick();
    do_one("st0a", 0, 32'h1, 32'd1, 6'd0, 32'h2);
    do_one("st1a", 1, 32'h1, 32'd2, 6'd0, 32'h4);
    do_one("st0b", 0, 32'h1, 32'd3, 6'd0, 32'h8);
    do_one("st1b", 1, 32'h1, 32'd4, 6'd0, 32'h10);
    do_one("st0c", 0, 32'h1, 32'd5, 6'd0, 32'h20);
    @(negedge clk);
    check("cnt0", {16'd0, grant_cnt0}, 32'd3);
    check("cnt1", {16'd0, grant_cnt1}, 32'd2);
    force dut.cnt0_q = 16'hFFFF;
    tick();
    release dut.cnt0_q;
    do_one("sat", 0, 32'h1, 32'd1, 6'd0, 32'h2);
    @(negedge clk);
    check("cnt0_sat", {16'd0, grant_cnt0}, 32'h0000_FFFF);
`endif

    repeat (3) tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Sequencer and arbiter that shares a single combinational 32-bit barrel-shifter instance between two requesters: requester 0 is the EX-stage ALU, requester 1 is the multi-cycle mult/div unit.
- Accepts one shift request at a time under valid/ready handshakes and drives the shifter's A/B/Signal inputs from registered operands.
- Captures the shifter result into a response register and returns it, tagged with the requester id, under a valid/ready handshake.

Parameters:
- WIDTH, 32, operand and result width; must match the shifter datapath.
- OPW, 6, width of the operation code forwarded to the shifter Signal input.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  request 0 accepted this cycle.
- req0_a  input  WIDTH  requester 0 value to shift.
- req0_b  input  WIDTH  requester 0 shift amount.
- req0_op  input  OPW  requester 0 operation (SLL = 6'b000000).
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- sh_a  output  WIDTH  to shifter A.
- sh_b  output  WIDTH  to shifter B.
- sh_op  output  OPW  to shifter Signal.
- sh_rst  output  1  to shifter reset input; equals reset.
- sh_result  input  WIDTH  from shifter dataOut.
- resp_valid  output  1  response available.
- resp_id  output  1  requester id owning the response.
- resp_data  output  WIDTH  captured shift result.
- resp_ready  input  1  consumer accepts the response.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset values: state=IDLE; resp_valid=0; resp_id=0; resp_data=0; sh_a/sh_b/sh_op operand registers=0; last_grant=1, so requester 0 wins the first contention.
- IDLE:
  - req0_ready and req1_ready are combinational and asserted only in IDLE, and only for the granted requester.
  - Grant rule: if exactly one valid, grant it. If both valid, grant the requester not equal to last_grant (round-robin).
  - On grant: latch a/b/op and id, update last_grant, go to EXEC.
  - At most one ready is high per cycle. Both readys are 0 outside IDLE.
- EXEC (exactly 1 cycle):
  - Shifter inputs are stable from the registers.
  - At the end of the cycle, resp_data <= sh_result, resp_id <= latched id, resp_valid <= 1, go to RESP.
- RESP:
  - Hold resp_valid, resp_id and resp_data stable until resp_ready=1.
  - On the resp_ready cycle: resp_valid <= 0, go to IDLE.
  - No new grant in the same cycle as the response handshake (single outstanding request).
- Latency: accept at cycle N gives resp_valid at N+2. Minimum issue interval is 3 cycles with resp_ready tied high.
- Operand registers retain their last values after completion; sh_* outputs change only on a grant.
- Arithmetic is performed entirely by the shifter and passed through unmodified:
  - B >= 32 yields 0.
  - A non-SLL op yields 0.
- Reset mid-operation, in any state: next cycle state=IDLE, resp_valid=0, the in-flight request is dropped with no response, and last_grant=1.
- A requester dropping valid before being granted is legal; it loses nothing.
- Request fields are sampled only in the grant cycle.

Optional Feature:
- Macro SHIFT_ARB_STATS_EN.
- When defined, add ports grant_cnt0 and grant_cnt1 (outputs, 16 bits each):
  - Each counts grants to its requester.
  - Each saturates at 16'hFFFF.
  - Both are cleared by reset.
  - A counter increments in the grant cycle and is visible the following cycle.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request: req0 a=32'h0000_0001, b=4, op=0, resp_ready=1 -> req0_ready in cycle N; resp_valid at N+2 with resp_id=0, resp_data=32'h0000_0010; return to IDLE at N+3.
- Contention after reset: req0 and req1 both valid, each with a=32'h8000_0001, b=1 -> requester 0 granted first, resp_data=32'h0000_0002; then requester 1 granted; grants alternate 0,1,0,1 while both stay valid.
- Out-of-range and unsupported op: b=32 -> resp_data=0; a=32'hFFFF_FFFF, b=1, op=6'b000010 -> resp_data=0.
- Backpressure: resp_ready=0 for 5 cycles -> resp_valid, resp_id and resp_data held stable; both readys held 0; after resp_ready=1, next grant no earlier than the following cycle.
- Reset during EXEC and during RESP -> resp_valid=0 next cycle; no response emitted for the dropped request; next contention grants requester 0.
- With SHIFT_ARB_STATS_EN defined: 3 grants to req0 and 2 to req1 -> grant_cnt0=3, grant_cnt1=2. With a counter forced to 16'hFFFF and one more grant -> it stays at 16'hFFFF.
